stack_memory: RTL and testbench

STACK_MEMORY -- requirements
Module: stack_memory

---
 rtl/stack_memory_pkg.sv | 26 ++
 rtl/stack_ptr_alu.sv | 41 ++++
 rtl/stack_memory.sv | 131 +++++++++++++
 tb/tb_stack_memory.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/stack_memory_pkg.sv
// -----------------------------------------------------------------------------
// stack_memory_pkg
// Shared definitions for the return-address stack pointer unit:
//   - default pointer width and per-operation step size
//   - 2-bit operation encoding decoded from the push/pop request pair
//   - decode helper that maps the raw request pair to the encoding
// -----------------------------------------------------------------------------
package stack_memory_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int STEP_DEF   = 4;

    // Bit 0 is the push request and bit 1 is the pop request, so the raw
    // request pair maps one-to-one onto the encoding.
    typedef enum logic [1:0] {
        OP_IDLE     = 2'b00,
        OP_PUSH     = 2'b01,
        OP_POP      = 2'b10,
        OP_CONFLICT = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push_req, input logic pop_req);
        return stack_op_e'({pop_req, push_req});
    endfunction

endpackage : stack_memory_pkg

// File: rtl/stack_ptr_alu.sv
// -----------------------------------------------------------------------------
// stack_ptr_alu
// Purely combinational pointer arithmetic. Produces both the decremented
// (push) and incremented (pop) pointer, each with the bit that fell off the
// top of the DATA_W-bit result.
// Ports:
//   ptr      in   DATA_W  current stack pointer
//   dec_ptr  out  DATA_W  ptr - STEP modulo 2^DATA_W
//   borrow   out  1       ptr < STEP (subtraction wrapped below 0)
//   inc_ptr  out  DATA_W  ptr + STEP modulo 2^DATA_W
//   carry    out  1       ptr + STEP exceeded 2^DATA_W-1
// -----------------------------------------------------------------------------
module stack_ptr_alu #(
    parameter int DATA_W = 32,
    parameter int STEP   = 4
) (
    input  logic [DATA_W-1:0] ptr,
    output logic [DATA_W-1:0] dec_ptr,
    output logic              borrow,
    output logic [DATA_W-1:0] inc_ptr,
    output logic              carry
);

    // One extra bit so the borrow/carry lands in the MSB of the result.
    localparam logic [DATA_W:0] STEP_EXT = (DATA_W+1)'(STEP);

    logic [DATA_W:0] dec_ext_s;
    logic [DATA_W:0] inc_ext_s;

    // Widened add/subtract; a wrapped subtraction sets the extra MSB.
    always_comb begin
        dec_ext_s = {1'b0, ptr} - STEP_EXT;
        inc_ext_s = {1'b0, ptr} + STEP_EXT;
    end

    assign dec_ptr = dec_ext_s[DATA_W-1:0];
    assign borrow  = dec_ext_s[DATA_W];
    assign inc_ptr = inc_ext_s[DATA_W-1:0];
    assign carry   = inc_ext_s[DATA_W];

endmodule : stack_ptr_alu

// File: rtl/stack_memory.sv
// -----------------------------------------------------------------------------
// stack_memory
// Stack-pointer update unit for jump-and-link / jump-to-stack. Each cycle it
// samples the request pair and the current pointer and, one cycle later,
// presents the next pointer, the data-RAM word address and the RAM strobes.
// Push pre-decrements (address = new pointer); pop reads the current top and
// post-increments. Wrapping is not saturated; it is only flagged.
// Ports:
//   clk               in   1       clock, rising edge
//   rst_n             in   1       synchronous active-low reset
//   JAL_signal        in   1       push request
//   JS_signal         in   1       pop request
//   Top_Stack_old     in   DATA_W  current stack pointer
//   Top_Stack_new     out  DATA_W  next stack pointer (registered)
//   RAM_addr          out  DATA_W  RAM word address (registered)
//   Store_RAM_signal  out  1       RAM write pulse for a push
//   Load_RAM_signal   out  1       RAM read pulse for a pop
//   stack_overflow    out  1       push wrapped below address 0
//   stack_underflow   out  1       pop wrapped above 2^DATA_W-1
// -----------------------------------------------------------------------------
module stack_memory
    import stack_memory_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int STEP   = STEP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              JAL_signal,
    input  logic              JS_signal,
    input  logic [DATA_W-1:0] Top_Stack_old,
    output logic [DATA_W-1:0] Top_Stack_new,
    output logic [DATA_W-1:0] RAM_addr,
    output logic              Store_RAM_signal,
    output logic              Load_RAM_signal,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    stack_op_e         op_s;
    logic [DATA_W-1:0] dec_ptr_s;
    logic              borrow_s;
    logic [DATA_W-1:0] inc_ptr_s;
    logic              carry_s;

    logic [DATA_W-1:0] nxt_ptr_s;
    logic [DATA_W-1:0] nxt_addr_s;
    logic              nxt_store_s;
    logic              nxt_load_s;
    logic              nxt_ovf_s;
    logic              nxt_unf_s;

    logic [DATA_W-1:0] ptr_r;
    logic [DATA_W-1:0] addr_r;
    logic              store_r;
    logic              load_r;
    logic              ovf_r;
    logic              unf_r;

    assign op_s = decode_op(JAL_signal, JS_signal);

    stack_ptr_alu #(
        .DATA_W (DATA_W),
        .STEP   (STEP)
    ) u_alu (
        .ptr     (Top_Stack_old),
        .dec_ptr (dec_ptr_s),
        .borrow  (borrow_s),
        .inc_ptr (inc_ptr_s),
        .carry   (carry_s)
    );

    // Next-cycle response decode; idle and conflicting requests pass the pointer through.
    always_comb begin
        nxt_ptr_s   = Top_Stack_old;
        nxt_addr_s  = Top_Stack_old;
        nxt_store_s = 1'b0;
        nxt_load_s  = 1'b0;
        nxt_ovf_s   = 1'b0;
        nxt_unf_s   = 1'b0;
        case (op_s)
            OP_PUSH: begin
                nxt_ptr_s   = dec_ptr_s;
                nxt_addr_s  = dec_ptr_s;
                nxt_store_s = 1'b1;
                nxt_ovf_s   = borrow_s;
            end
            OP_POP: begin
                nxt_ptr_s  = inc_ptr_s;
                nxt_addr_s = Top_Stack_old;
                nxt_load_s = 1'b1;
                nxt_unf_s  = carry_s;
            end
            OP_IDLE, OP_CONFLICT: begin
                nxt_ptr_s  = Top_Stack_old;
                nxt_addr_s = Top_Stack_old;
            end
            default: begin
                nxt_ptr_s  = Top_Stack_old;
                nxt_addr_s = Top_Stack_old;
            end
        endcase
    end

    // Output registers; reset clears everything and discards the sampled request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r   <= {DATA_W{1'b0}};
            addr_r  <= {DATA_W{1'b0}};
            store_r <= 1'b0;
            load_r  <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            ptr_r   <= nxt_ptr_s;
            addr_r  <= nxt_addr_s;
            store_r <= nxt_store_s;
            load_r  <= nxt_load_s;
            ovf_r   <= nxt_ovf_s;
            unf_r   <= nxt_unf_s;
        end
    end

    assign Top_Stack_new    = ptr_r;
    assign RAM_addr         = addr_r;
    assign Store_RAM_signal = store_r;
    assign Load_RAM_signal  = load_r;
    assign stack_overflow   = ovf_r;
    assign stack_underflow  = unf_r;

endmodule : stack_memory

// File: tb/tb_stack_memory.sv
// -----------------------------------------------------------------------------
// tb_stack_memory
// Self-checking bench for stack_memory: a table of directed vectors, short
// hand-written sequences for reset and held requests, and a random run
// checked against an independent arithmetic model. Expected responses are
// queued when stimulus is driven and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_stack_memory;

    typedef struct packed {
        logic [31:0] nw;
        logic [31:0] addr;
        logic        st;
        logic        ld;
        logic        ov;
        logic        un;
    } exp_t;

    typedef struct {
        logic        rst_n;
        logic        jal;
        logic        js;
        logic [31:0] old;
        exp_t        exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        jal;
    logic        js;
    logic [31:0] old;
    logic [31:0] top_new;
    logic [31:0] ram_addr;
    logic        store;
    logic        load;
    logic        ovf;
    logic        unf;

    int   checks;
    int   failures;
    exp_t sb_q[$];
    vec_t tbl[12];

    stack_memory dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .JAL_signal       (jal),
        .JS_signal        (js),
        .Top_Stack_old    (old),
        .Top_Stack_new    (top_new),
        .RAM_addr         (ram_addr),
        .Store_RAM_signal (store),
        .Load_RAM_signal  (load),
        .stack_overflow   (ovf),
        .stack_underflow  (unf)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] nw, input logic [31:0] addr,
                                input logic st, input logic ld,
                                input logic ov, input logic un);
        exp_t e;
        e.nw = nw; e.addr = addr; e.st = st; e.ld = ld; e.ov = ov; e.un = un;
        return e;
    endfunction

    // Reference behaviour written from the arithmetic definition of the unit.
    function automatic exp_t model(input logic r, input logic p, input logic q,
                                   input logic [31:0] o);
        exp_t e;
        logic [32:0] wide;
        e = mk(o, o, 1'b0, 1'b0, 1'b0, 1'b0);
        if (!r) begin
            e = mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (p && !q) begin
            wide = {1'b0, o} + 33'h1_FFFF_FFFC; // o - 4 as a 33-bit sum
            e = mk(wide[31:0], wide[31:0], 1'b1, 1'b0, (o < 32'd4), 1'b0);
        end else if (q && !p) begin
            wide = {1'b0, o} + 33'd4;
            e = mk(wide[31:0], o, 1'b0, 1'b1, 1'b0, wide[32]);
        end
        return e;
    endfunction

    task automatic check(input string name);
        exp_t e;
        exp_t a;
        a = {top_new, ram_addr, store, load, ovf, unf};
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got new=%h addr=%h st=%b ld=%b ov=%b un=%b expected new=%h addr=%h st=%b ld=%b ov=%b un=%b",
                         name, a.nw, a.addr, a.st, a.ld, a.ov, a.un,
                         e.nw, e.addr, e.st, e.ld, e.ov, e.un);
            end
        end
        checks++;
        if (store && load) begin
            failures++;
            $display("FAIL %s_strobe_excl: got st=%b ld=%b expected not both 1", name, store, load);
        end
    endtask

    task automatic drive(input string name, input logic r, input logic p, input logic q,
                         input logic [31:0] o, input exp_t e);
        rst_n = r;
        jal   = p;
        js    = q;
        old   = o;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        jal      = 1'b0;
        js       = 1'b0;
        old      = 32'h0;
        checks   = 0;
        failures = 0;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, mk(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0)};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, mk(32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1)};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, mk(32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, mk(32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_1000, mk(32'h0000_1000, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, mk(32'h0000_1234, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0004, mk(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0003, mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0)};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFB, mk(32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, mk(32'h0000_0000, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b1)};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0000_1000, mk(32'h0000_0FFC, 32'h0000_0FFC, 1'b1, 1'b0, 1'b0, 1'b0)};

        // Reset state after a couple of reset edges.
        @(posedge clk);
        #1;
        drive("reset_idle", 1'b0, 1'b0, 1'b0, 32'h0, mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < 12; i++) begin
            drive($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].jal, tbl[i].js,
                  tbl[i].old, tbl[i].exp);
        end

        // Push pending when reset hits, then idle after release.
        drive("pre_rst_push", 1'b1, 1'b1, 1'b0, 32'h0000_0020,
              mk(32'h0000_001C, 32'h0000_001C, 1'b1, 1'b0, 1'b0, 1'b0));
        drive("rst_cancel", 1'b0, 1'b1, 1'b0, 32'h0000_0020,
              mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        drive("post_rst_idle", 1'b1, 1'b0, 1'b0, 32'h0000_0010,
              mk(32'h0000_0010, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0));

        // Push held for three cycles: each is its own operation on the sampled old.
        drive("hold_push0", 1'b1, 1'b1, 1'b0, 32'h0000_0030,
              mk(32'h0000_002C, 32'h0000_002C, 1'b1, 1'b0, 1'b0, 1'b0));
        drive("hold_push1", 1'b1, 1'b1, 1'b0, 32'h0000_002C,
              mk(32'h0000_0028, 32'h0000_0028, 1'b1, 1'b0, 1'b0, 1'b0));
        drive("hold_push2", 1'b1, 1'b1, 1'b0, 32'h0000_0008,
              mk(32'h0000_0004, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b0));
        // Pop held twice with the same old: identical response both cycles.
        drive("hold_pop0", 1'b1, 1'b0, 1'b1, 32'h0000_0040,
              mk(32'h0000_0044, 32'h0000_0040, 1'b0, 1'b1, 1'b0, 1'b0));
        drive("hold_pop1", 1'b1, 1'b0, 1'b1, 32'h0000_0040,
              mk(32'h0000_0044, 32'h0000_0040, 1'b0, 1'b1, 1'b0, 1'b0));
        drive("pulse_end", 1'b1, 1'b0, 1'b0, 32'h0000_0044,
              mk(32'h0000_0044, 32'h0000_0044, 1'b0, 1'b0, 1'b0, 1'b0));

        // Random traffic including pointers near both wrap boundaries.
        for (int i = 0; i < 40; i++) begin
            logic        r, p, q;
            logic [31:0] o;
            r = ($urandom_range(0, 15) != 0);
            p = $urandom_range(0, 1);
            q = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0:       o = 32'($urandom_range(0, 7));
                1:       o = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                default: o = $urandom;
            endcase
            drive($sformatf("rand%0d", i), r, p, q, o, model(r, p, q, o));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stack_memory
